// File: rtl/load_store_unit_if.sv
// Request/response handshake between the datapath and the load/store unit.
// The datapath is the master; the load/store unit is the slave.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        resp_done;
    logic        resp_fault;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid,
        output req_write,
        output req_funct3,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  resp_done,
        input  resp_fault,
        input  resp_rdata
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output resp_done,
        output resp_fault,
        output resp_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit on a 4-byte-wide memory word port.
// Sub-word stores are done as read-modify-write of the word at addr.
module load_store_unit #(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic               clk,
    input  logic               reset,
    load_store_unit_if.slave   bus,
    output logic [31:0]        mem_address,
    output logic [31:0]        mem_wdata,
    output logic               mem_read,
    output logic               mem_write,
    input  logic [31:0]        mem_rdata
);
    localparam logic [31:0] MAX_ADDR = 32'(MEM_BYTES - 4);

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        RESP
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        write_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic        fault_q;
    logic [31:0] rdata_q;

    logic        accept;
    logic        f3_ok;
    logic        align_ok;
    logic        req_fault;
    logic [31:0] load_ext;

    assign accept = bus.req_valid && (state_q == IDLE);

    always_comb begin
        f3_ok = 1'b0;
        case (bus.req_funct3)
            3'd0, 3'd1, 3'd2: f3_ok = 1'b1;
            3'd4, 3'd5:       f3_ok = !bus.req_write;
            default:          f3_ok = 1'b0;
        endcase
    end

    // funct3[1:0] encodes the access width for every legal code
    always_comb begin
        align_ok = 1'b1;
        case (bus.req_funct3[1:0])
            2'b01:   align_ok = !bus.req_addr[0];
            2'b10:   align_ok = (bus.req_addr[1:0] == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    assign req_fault = !f3_ok || !align_ok || (bus.req_addr > MAX_ADDR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_fault) begin
                        state_d = RESP;
                    end else if (bus.req_write &&
                                 bus.req_funct3 == 3'd2) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:      state_d = write_q ? WR : RESP;
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        load_ext = mem_rdata;
        case (funct3_q)
            3'd0: load_ext = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'd1: load_ext = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'd4: load_ext = {24'd0, mem_rdata[7:0]};
            3'd5: load_ext = {16'd0, mem_rdata[15:0]};
            default: load_ext = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            merge_q  <= 32'd0;
            fault_q  <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                write_q  <= bus.req_write;
                funct3_q <= bus.req_funct3;
                addr_q   <= bus.req_addr;
                wdata_q  <= bus.req_wdata;
                fault_q  <= req_fault;
            end
            if (state_q == RD) begin
                if (write_q) begin
                    merge_q <= mem_rdata;
                end else begin
                    rdata_q <= load_ext;
                end
            end
        end
    end

    // Upper bytes come back from the RD cycle so the word write is a no-op there
    always_comb begin
        mem_wdata = wdata_q;
        case (funct3_q[1:0])
            2'b00:   mem_wdata = {merge_q[31:8], wdata_q[7:0]};
            2'b01:   mem_wdata = {merge_q[31:16], wdata_q[15:0]};
            default: mem_wdata = wdata_q;
        endcase
    end

    assign mem_address    = addr_q;
    assign mem_read       = reset && (state_q == RD);
    assign mem_write      = reset && (state_q == WR);
    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_done  = (state_q == RESP);
    assign bus.resp_fault = (state_q == RESP) && fault_q;
    assign bus.resp_rdata = rdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed table, reset/back-to-back
// sequences, and random requests against a byte-array reference model.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    load_store_unit_if bus();

    load_store_unit #(.MEM_BYTES(256)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] ref_mem [256] = '{default: 8'h00};

    logic [7:0] ma;
    assign ma = mem_address[7:0];
    assign mem_rdata = {mem[8'(ma + 8'd3)], mem[8'(ma + 8'd2)],
                        mem[8'(ma + 8'd1)], mem[ma]};

    always @(posedge clk) begin
        if (mem_write) begin
            mem[ma]              <= mem_wdata[7:0];
            mem[8'(ma + 8'd1)]   <= mem_wdata[15:8];
            mem[8'(ma + 8'd2)]   <= mem_wdata[23:16];
            mem[8'(ma + 8'd3)]   <= mem_wdata[31:24];
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] last_rdata = 32'd0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_fault(logic w, logic [2:0] f3,
                                     logic [31:0] a);
        logic bad_f3;
        int   width;
        if (w) bad_f3 = (f3 > 3'd2);
        else   bad_f3 = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        width = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
        return bad_f3 || (a > 32'd252) || ((a % width) != 0);
    endfunction

    function automatic logic [31:0] m_word(logic [31:0] a);
        int i;
        i = int'(a[7:0]);
        return {ref_mem[i + 3], ref_mem[i + 2], ref_mem[i + 1], ref_mem[i]};
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a);
        logic [31:0] wd;
        int v;
        wd = m_word(a);
        case (f3)
            3'd0: v = int'(wd[7:0]) - (wd[7] ? 256 : 0);
            3'd1: v = int'(wd[15:0]) - (wd[15] ? 65536 : 0);
            3'd4: v = int'(wd[7:0]);
            3'd5: v = int'(wd[15:0]);
            default: v = int'(wd);
        endcase
        return 32'(v);
    endfunction

    task automatic m_store(logic [2:0] f3, logic [31:0] a,
                           logic [31:0] d);
        int n;
        n = (f3 == 3'd2) ? 4 : ((f3 == 3'd1) ? 2 : 1);
        for (int k = 0; k < n; k++)
            ref_mem[int'(a[7:0]) + k] = 8'(d >> (8 * k));
    endtask

    function automatic int m_lat(logic w, logic [2:0] f3, logic [31:0] a);
        if (m_fault(w, f3, a)) return 1;
        if (!w || f3 == 3'd2) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] mem_word(int i);
        return {mem[i + 3], mem[i + 2], mem[i + 1], mem[i]};
    endfunction

    // ---------------- one request, fully checked ----------------
    task automatic run_req(string nm, logic w, logic [2:0] f3,
                           logic [31:0] a, logic [31:0] wd,
                           logic ef, logic [31:0] erd, int elat);
        int got_lat = 0;
        int n_rd = 0;
        int n_wr = 0;
        int viol = 0;
        int ci;
        logic got_f = 1'b0;
        logic [31:0] got_rd = 32'd0;
        @(negedge clk);
        chk({nm, "_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_read) n_rd++;
            if (mem_write) n_wr++;
            if (mem_read && mem_write) viol++;
            if ((mem_read || mem_write) && mem_address !== a) viol++;
            if (bus.resp_done) begin
                got_lat = k;
                got_f   = bus.resp_fault;
                got_rd  = bus.resp_rdata;
                break;
            end
            if (bus.resp_fault) viol++;
        end
        if (w && !ef) m_store(f3, a, wd);
        chk({nm, "_lat"}, 32'(got_lat), 32'(elat));
        chk({nm, "_fault"}, 32'(got_f), 32'(ef));
        chk({nm, "_rdata"}, got_rd, erd);
        chk({nm, "_nrd"}, 32'(n_rd), 32'(!ef && (!w || f3 != 3'd2)));
        chk({nm, "_nwr"}, 32'(n_wr), 32'(!ef && w));
        chk({nm, "_bus"}, 32'(viol), 32'd0);
        ci = (a > 32'd252) ? 252 : int'(a[7:0]);
        chk({nm, "_mem"}, mem_word(ci), m_word(32'(ci)));
        last_rdata = erd;
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        fault;
        logic [31:0] rd;
        int          lat;
    } vec_t;

    vec_t tbl[18];

    task automatic reset_mid_store();
        logic seen = 1'b0;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b1;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'h90;
        bus.req_wdata  = 32'hA5A5_A5EE;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (mem_write) begin
                seen = 1'b1;
                break;
            end
        end
        chk("rst_wr_seen", 32'(seen), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_wr_gate", 32'(mem_write), 32'd0);
        chk("rst_rd_gate", 32'(mem_read), 32'd0);
        @(negedge clk);
        chk("rst_no_done", 32'(bus.resp_done), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rdata", bus.resp_rdata, 32'd0);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_quiet", 32'(bus.resp_done), 32'd0);
        end
        chk("rst_mem", mem_word(32'h90), m_word(32'h90));
        last_rdata = 32'd0;
    endtask

    task automatic back_to_back();
        logic        ws  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [2:0]  fs  [4] = '{3'd2, 3'd0, 3'd2, 3'd1};
        logic [31:0] as  [4] = '{32'hA0, 32'hA1, 32'hA0, 32'hA2};
        logic [31:0] ds  [4] = '{32'h1122_3344, 32'h0000_0055, 0, 0};
        logic [31:0] erd;
        logic        ef;
        logic        take;
        int acc = 0;
        int dn = 0;
        int idx = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        for (int c = 0; c < 40 && dn < 4; c++) begin
            if (take == 1'b0 || c == 0) begin end
            if (c == 0 || bus.resp_done) begin
                bus.req_write  = ws[idx];
                bus.req_funct3 = fs[idx];
                bus.req_addr   = as[idx];
                bus.req_wdata  = ds[idx];
                ef  = m_fault(ws[idx], fs[idx], as[idx]);
                erd = (!ws[idx] && !ef) ? m_load(fs[idx], as[idx])
                                        : last_rdata;
                if (ws[idx] && !ef) m_store(fs[idx], as[idx], ds[idx]);
            end
            take = bus.req_ready && bus.req_valid;
            @(posedge clk);
            if (take) acc++;
            @(negedge clk);
            if (bus.resp_done) begin
                chk($sformatf("b2b%0d_rdata", dn), bus.resp_rdata, erd);
                chk($sformatf("b2b%0d_fault", dn), 32'(bus.resp_fault),
                    32'(ef));
                last_rdata = erd;
                dn++;
                idx++;
                if (idx == 4) bus.req_valid = 1'b0;
            end
        end
        bus.req_valid = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'd4);
        chk("b2b_dones", 32'(dn), 32'd4);
        chk("b2b_mem", mem_word(32'hA0), 32'h1122_5544);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        w;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic        ef;
        logic [31:0] erd;

        tbl[0]  = '{1'b1, 3'd2, 32'h80, 32'h8000_00F0, 1'b0, 32'h0, 2};
        tbl[1]  = '{1'b0, 3'd0, 32'h80, 32'h0, 1'b0, 32'hFFFF_FFF0, 2};
        tbl[2]  = '{1'b0, 3'd4, 32'h80, 32'h0, 1'b0, 32'h0000_00F0, 2};
        tbl[3]  = '{1'b0, 3'd1, 32'h82, 32'h0, 1'b0, 32'hFFFF_8000, 2};
        tbl[4]  = '{1'b1, 3'd0, 32'h81, 32'h1234_56AB, 1'b0,
                    32'hFFFF_8000, 3};
        tbl[5]  = '{1'b0, 3'd2, 32'h80, 32'h0, 1'b0, 32'h8000_ABF0, 2};
        tbl[6]  = '{1'b1, 3'd2, 32'h84, 32'hDEAD_BEEF, 1'b0,
                    32'h8000_ABF0, 2};
        tbl[7]  = '{1'b1, 3'd1, 32'h86, 32'h0000_1234, 1'b0,
                    32'h8000_ABF0, 3};
        tbl[8]  = '{1'b0, 3'd2, 32'h84, 32'h0, 1'b0, 32'h1234_BEEF, 2};
        tbl[9]  = '{1'b0, 3'd2, 32'h82, 32'h0, 1'b1, 32'h1234_BEEF, 1};
        tbl[10] = '{1'b1, 3'd1, 32'h85, 32'h5555, 1'b1, 32'h1234_BEEF, 1};
        tbl[11] = '{1'b0, 3'd0, 32'hFD, 32'h0, 1'b1, 32'h1234_BEEF, 1};
        tbl[12] = '{1'b0, 3'd3, 32'h80, 32'h0, 1'b1, 32'h1234_BEEF, 1};
        tbl[13] = '{1'b1, 3'd4, 32'h80, 32'h77, 1'b1, 32'h1234_BEEF, 1};
        tbl[14] = '{1'b0, 3'd5, 32'h86, 32'h0, 1'b0, 32'h0000_1234, 2};
        tbl[15] = '{1'b0, 3'd2, 32'hFC, 32'h0, 1'b0, 32'h0000_0000, 2};
        tbl[16] = '{1'b1, 3'd1, 32'hFE, 32'h9999, 1'b1, 32'h0, 1};
        tbl[17] = '{1'b0, 3'd1, 32'h80, 32'h0, 1'b0, 32'hFFFF_ABF0, 2};

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", 32'(bus.req_ready), 32'd1);
        chk("rst_done0", 32'(bus.resp_done), 32'd0);
        chk("rst_fault0", 32'(bus.resp_fault), 32'd0);
        chk("rst_rdata0", bus.resp_rdata, 32'd0);
        chk("rst_addr0", mem_address, 32'd0);
        chk("rst_wdata0", mem_wdata, 32'd0);
        chk("rst_rdwr0", {30'd0, mem_read, mem_write}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++)
            run_req($sformatf("tbl%0d", i), tbl[i].w, tbl[i].f3,
                    tbl[i].a, tbl[i].wd, tbl[i].fault, tbl[i].rd,
                    tbl[i].lat);

        reset_mid_store();
        back_to_back();

        for (int i = 0; i < 200; i++) begin
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else a = 32'($urandom_range(32'h60, 32'hFF));
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            wd  = $urandom;
            ef  = m_fault(w, f3, a);
            erd = (!w && !ef) ? m_load(f3, a) : last_rdata;
            run_req($sformatf("rnd%0d", i), w, f3, a, wd, ef, erd,
                    m_lat(w, f3, a));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
